// File: rtl/cv_mem_pkg.sv
// Shared types for the cartridge SDRAM arbiter: FSM states, loader FIFO entry
// format and cart page extraction.
package cv_mem_pkg;

  localparam int CART_ADDR_W   = 25;
  localparam int CART_PAGE_LSB = 14;
  localparam int CART_PAGE_W   = 6;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [CART_ADDR_W-1:0] addr;
    logic [7:0]             data;
  } wr_entry_t;

  function automatic logic [CART_PAGE_W-1:0] cart_page(input logic [CART_ADDR_W-1:0] a);
    return a[CART_PAGE_LSB +: CART_PAGE_W];
  endfunction

endpackage

// File: rtl/cart_mem_arbiter_fifo.sv
// Loader write buffer: synchronous FIFO of {addr,data} entries with
// wrapping pointers and a one-bit-wider occupancy count.
module cart_wr_fifo
  import cv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  wr_entry_t din_i,
  input  logic      pop_i,
  output wr_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees the slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge SDRAM port between buffered loader byte writes and
// console cart reads, with a bound on how long reads may starve writes.
module cart_mem_arbiter
  import cv_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 25,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_data_i,
  output logic              dl_full_o,
  output logic              dl_ovf_o,
  input  logic              cart_rd_i,
  input  logic [19:0]       cart_a_i,
  output logic [7:0]        cart_d_o,
  output logic              cart_valid_o,
  output logic [5:0]        cart_pages_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_din_o,
  output logic              mem_we_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_dout_i,
  input  logic              mem_ready_i
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state_q;
  logic [STV_W-1:0]  starve_q;
  logic              mem_we_q, mem_rd_q, cart_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q, cart_d_q;
  logic              dl_active_q, dl_ovf_q;
  logic [5:0]        pages_q;
  logic              rd_pend_q;
  logic [19:0]       rd_addr_q;

  wr_entry_t fifo_in, fifo_head;
  logic      fifo_full, fifo_empty, fifo_pop, dl_accept, dl_rise, reads_ok;

  assign fifo_in.addr = CART_ADDR_W'(dl_addr_i);
  assign fifo_in.data = dl_data_i;
  assign fifo_pop     = (state_q == WR_REQ);
  assign dl_accept    = dl_wr_i && (!fifo_full || fifo_pop);
  assign dl_rise      = dl_active_i && !dl_active_q;
  assign reads_ok     = rd_pend_q && !dl_active_i;

  cart_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .push_i  (dl_wr_i),
    .din_i   (fifo_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Loader bookkeeping: a new download clears the sticky overflow and page
  // count, but an accepted byte in the same cycle still records its page.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dl_active_q <= 1'b0;
      dl_ovf_q    <= 1'b0;
      pages_q     <= '0;
    end else begin
      dl_active_q <= dl_active_i;
      if (dl_rise) begin
        dl_ovf_q <= 1'b0;
        pages_q  <= '0;
      end
      if (dl_accept)    pages_q  <= cart_page(fifo_in.addr);
      else if (dl_wr_i) dl_ovf_q <= 1'b1;
    end
  end

  // Single-slot read request latch; the latest strobe wins and a strobe that
  // lands while the request is being issued re-arms it for another access.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
    end else if (dl_active_i) begin
      rd_pend_q <= 1'b0;
    end else if (cart_rd_i) begin
      rd_pend_q <= 1'b1;
      rd_addr_q <= cart_a_i;
    end else if (state_q == RD_REQ) begin
      rd_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      cart_d_q     <= '0;
      cart_valid_q <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      cart_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reads_ok && (fifo_empty || starve_q < STV_W'(STARVE_MAX))) begin
            state_q    <= RD_REQ;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(rd_addr_q);
            if (!fifo_empty) starve_q <= starve_q + 1'b1;
          end else if (!fifo_empty) begin
            state_q    <= WR_REQ;
            mem_we_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(fifo_head.addr);
            mem_din_q  <= fifo_head.data;
            starve_q   <= '0;
          end
        end
        WR_REQ:  state_q <= WR_WAIT;
        RD_REQ:  state_q <= RD_WAIT;
        WR_WAIT: if (mem_ready_i) state_q <= IDLE;
        RD_WAIT: begin
          if (mem_ready_i) begin
            cart_d_q     <= mem_dout_i;
            cart_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dl_full_o    = fifo_full;
  assign dl_ovf_o     = dl_ovf_q;
  assign cart_pages_o = pages_q;
  assign cart_d_o     = cart_d_q;
  assign cart_valid_o = cart_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign mem_we_o     = mem_we_q;
  assign mem_rd_o     = mem_rd_q;

endmodule
